motor_ramp_ctrl: RTL and testbench

APB3 peripheral that holds the software motor command (target duty and direction per side) and drives the PWM stage with slew-limited values. Duty moves toward target by a programmable step per ramp tick. A direction reversal always ramps to 0, holds 0 for a dead time, then flips direction. Outputs drive the duty/direction inputs of the H-bridge PWM stage directly, replacing direct register writes.

---
 rtl/motor_ramp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: APB3 motor command registers driving the H-bridge PWM stage with
// slew-limited duty per side and a dead-time guarded direction reversal.
module motor_ramp_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int DEAD_TICKS = 20
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [6:0]  RIGHT_DUTY,
  output logic [6:0]  LEFT_DUTY,
  output logic        RIGHT_FWD,
  output logic        LEFT_FWD
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DOWN,
    ST_DEAD
  } state_e;

  typedef struct packed {
    state_e            state;
    logic [6:0]        duty;
    logic              fwd;
    logic [DEAD_W-1:0] dead;
  } side_t;

  localparam side_t SIDE_RST = '{state: ST_RUN, duty: 7'd0, fwd: 1'b1, dead: '0};

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [15:0]      tgt_q, tgt_d;
  logic [6:0]       step_q, step_d;
  side_t            side_q [2];
  side_t            side_d [2];
  logic             tick;
  logic             wr_en;
  logic [1:0]       busy;
  logic             unused_bits;

  function automatic logic [6:0] clamp_duty(input logic [7:0] v);
    return (v > 8'd100) ? 7'd100 : v[6:0];
  endfunction

  // One ramp tick of a side; the caller only applies the result on tick cycles.
  function automatic side_t side_next(input side_t      cur,
                                      input logic       tgt_fwd,
                                      input logic [6:0] tgt_duty,
                                      input logic [6:0] step);
    side_t      nxt;
    logic [7:0] duty8;
    logic [7:0] tgt8;
    logic [7:0] up8;
    logic [7:0] dn8;
    nxt   = cur;
    duty8 = {1'b0, cur.duty};
    tgt8  = {1'b0, tgt_duty};
    up8   = duty8 + {1'b0, step};
    dn8   = (duty8 > {1'b0, step}) ? (duty8 - {1'b0, step}) : 8'd0;
    case (cur.state)
      ST_RUN: begin
        if (tgt_fwd != cur.fwd) begin
          nxt.state = ST_DOWN;
        end else if (duty8 < tgt8) begin
          nxt.duty = clamp_duty((up8 > tgt8) ? tgt8 : up8);
        end else begin
          nxt.duty = clamp_duty((dn8 < tgt8) ? tgt8 : dn8);
        end
      end
      ST_DOWN: begin
        if (tgt_fwd == cur.fwd) begin
          nxt.state = ST_RUN;
        end else if (cur.duty == 7'd0) begin
          nxt.state = ST_DEAD;
          nxt.dead  = DEAD_W'(DEAD_TICKS);
        end else begin
          nxt.duty = clamp_duty(dn8);
        end
      end
      ST_DEAD: begin
        nxt.duty = 7'd0;
        if (tgt_fwd == cur.fwd) begin
          nxt.state = ST_RUN;
        end else if (cur.dead <= DEAD_W'(1)) begin
          nxt.dead  = '0;
          nxt.fwd   = tgt_fwd;
          nxt.state = ST_RUN;
        end else begin
          nxt.dead = cur.dead - DEAD_W'(1);
        end
      end
      default: nxt.state = ST_RUN;
    endcase
    return nxt;
  endfunction

  assign tick  = (presc_q == CNT_W'(TICK_DIV - 1));
  assign wr_en = PSEL & PENABLE & PWRITE;

  // Side FSMs read the registered target, so a write on a tick cycle waits for the next tick.
  always_comb begin
    presc_d   = tick ? '0 : (presc_q + CNT_W'(1));
    tgt_d     = tgt_q;
    step_d    = step_q;
    side_d[0] = side_q[0];
    side_d[1] = side_q[1];
    if (wr_en) begin
      case (PADDR[3:2])
        2'd0: tgt_d = {clamp_duty({1'b0, PWDATA[15:9]}),
                       clamp_duty({1'b0, PWDATA[8:2]}),
                       PWDATA[1:0]};
        2'd1: step_d = (PWDATA[6:0] == 7'd0) ? 7'd1 : PWDATA[6:0];
        default: ;
      endcase
    end
    if (tick) begin
      side_d[0] = side_next(side_q[0], tgt_q[0], tgt_q[8:2], step_q);
      side_d[1] = side_next(side_q[1], tgt_q[1], tgt_q[15:9], step_q);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      presc_q   <= '0;
      tgt_q     <= 16'h0003;
      step_q    <= 7'd1;
      side_q[0] <= SIDE_RST;
      side_q[1] <= SIDE_RST;
    end else begin
      presc_q   <= presc_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      side_q[0] <= side_d[0];
      side_q[1] <= side_d[1];
    end
  end

  assign busy[0] = (side_q[0].state != ST_RUN) || (side_q[0].duty != tgt_q[8:2]);
  assign busy[1] = (side_q[1].state != ST_RUN) || (side_q[1].duty != tgt_q[15:9]);

  always_comb begin
    PRDATA = '0;
    case (PADDR[3:2])
      2'd0: PRDATA[15:0] = tgt_q;
      2'd1: PRDATA[6:0]  = step_q;
      2'd2: PRDATA[17:0] = {busy[1], busy[0], side_q[1].fwd, side_q[0].fwd,
                            side_q[1].duty, side_q[0].duty};
      default: ;
    endcase
  end

  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign RIGHT_DUTY  = side_q[0].duty;
  assign LEFT_DUTY   = side_q[1].duty;
  assign RIGHT_FWD   = side_q[0].fwd;
  assign LEFT_FWD    = side_q[1].fwd;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: register vectors, directed ramp/reversal/reset sequences and random
// APB traffic compared every cycle against an integer model of the ramp rules.
`timescale 1ns/1ps
module tb_motor_ramp_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DEAD_TICKS = 2;
  localparam int M_RUN  = 0;
  localparam int M_DOWN = 1;
  localparam int M_DEAD = 2;

  logic        PCLK    = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PADDR   = '0;
  logic [31:0] PWDATA  = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [6:0]  RIGHT_DUTY;
  logic [6:0]  LEFT_DUTY;
  logic        RIGHT_FWD;
  logic        LEFT_FWD;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  motor_ramp_ctrl #(.TICK_DIV(TICK_DIV), .DEAD_TICKS(DEAD_TICKS)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RIGHT_DUTY(RIGHT_DUTY), .LEFT_DUTY(LEFT_DUTY), .RIGHT_FWD(RIGHT_FWD), .LEFT_FWD(LEFT_FWD)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: index 0 = right, 1 = left; plain integers throughout.
  int m_cnt;
  int m_step;
  int m_tdir [2];
  int m_tdty [2];
  int m_duty [2];
  int m_fwd  [2];
  int m_mode [2];
  int m_dead [2];
  bit m_tick;
  bit m_rst;

  task automatic model_side(input int s);
    case (m_mode[s])
      M_RUN: begin
        if (m_tdir[s] != m_fwd[s]) m_mode[s] = M_DOWN;
        else if (m_duty[s] < m_tdty[s])
          m_duty[s] = (m_duty[s] + m_step > m_tdty[s]) ? m_tdty[s] : m_duty[s] + m_step;
        else
          m_duty[s] = (m_duty[s] - m_step < m_tdty[s]) ? m_tdty[s] : m_duty[s] - m_step;
      end
      M_DOWN: begin
        if (m_tdir[s] == m_fwd[s]) m_mode[s] = M_RUN;
        else if (m_duty[s] == 0) begin
          m_mode[s] = M_DEAD;
          m_dead[s] = DEAD_TICKS;
        end else m_duty[s] = (m_duty[s] > m_step) ? m_duty[s] - m_step : 0;
      end
      default: begin
        if (m_tdir[s] == m_fwd[s]) m_mode[s] = M_RUN;
        else begin
          m_dead[s] = m_dead[s] - 1;
          if (m_dead[s] == 0) begin
            m_fwd[s]  = m_tdir[s];
            m_mode[s] = M_RUN;
          end
        end
      end
    endcase
  endtask

  always @(posedge PCLK) begin
    m_tick = 1'b0;
    m_rst  = !PRESERN;
    if (!PRESERN) begin
      m_cnt  = 0;
      m_step = 1;
      for (int s = 0; s < 2; s++) begin
        m_tdir[s] = 1; m_tdty[s] = 0; m_duty[s] = 0;
        m_fwd[s]  = 1; m_mode[s] = M_RUN; m_dead[s] = 0;
      end
    end else begin
      if (m_cnt == TICK_DIV - 1) begin
        m_tick = 1'b1;
        m_cnt  = 0;
        model_side(0);
        model_side(1);
      end else m_cnt = m_cnt + 1;
      if (PSEL && PENABLE && PWRITE) begin
        if (PADDR[3:2] == 2'd0) begin
          m_tdir[0] = int'(PWDATA[0]);
          m_tdir[1] = int'(PWDATA[1]);
          m_tdty[0] = (int'(PWDATA[8:2]) > 100) ? 100 : int'(PWDATA[8:2]);
          m_tdty[1] = (int'(PWDATA[15:9]) > 100) ? 100 : int'(PWDATA[15:9]);
        end else if (PADDR[3:2] == 2'd1) begin
          m_step = (PWDATA[6:0] == 7'd0) ? 1 : int'(PWDATA[6:0]);
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input int a);
    int b0, b1;
    b0 = (m_mode[0] != M_RUN || m_duty[0] != m_tdty[0]) ? 1 : 0;
    b1 = (m_mode[1] != M_RUN || m_duty[1] != m_tdty[1]) ? 1 : 0;
    case (a)
      0: return 32'(m_tdir[0] + 2 * m_tdir[1] + 4 * m_tdty[0] + 512 * m_tdty[1]);
      1: return 32'(m_step);
      2: return 32'(m_duty[0] + 128 * m_duty[1] + 16384 * m_fwd[0] + 32768 * m_fwd[1]
                    + 65536 * b0 + 131072 * b1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_out();
    return 32'(32768 * m_fwd[0] + 16384 * m_fwd[1] + 128 * m_duty[0] + m_duty[1]);
  endfunction

  function automatic logic [31:0] pack_out();
    return {16'h0, RIGHT_FWD, LEFT_FWD, RIGHT_DUTY, LEFT_DUTY};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] paddr, input logic [31:0] wdata);
    PADDR = paddr; PWDATA = wdata; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [31:0] paddr, output logic [31:0] data);
    PADDR = paddr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    #1;
    data = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(posedge PCLK); #1;
      cycles++;
    end while (!m_tick && cycles < 4 * TICK_DIV);
    if (!m_tick) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL tick_timeout: got no tick in %0d cycles, expected one", cycles);
    end
  endtask

  // Every cycle: outputs against the model, and no direction flip unless duty was and stays 0.
  logic [6:0] prev_rd, prev_ld;
  logic       prev_rf, prev_lf;
  bit         have_prev = 1'b0;
  always @(posedge PCLK) begin
    #1;
    if (chk_en) begin
      checkOutput("outputs", pack_out(), model_out());
      if (have_prev && !m_rst) begin
        if (RIGHT_FWD != prev_rf) checkOutput("right_flip_at_zero", {18'h0, prev_rd, RIGHT_DUTY}, 32'h0);
        if (LEFT_FWD != prev_lf)  checkOutput("left_flip_at_zero", {18'h0, prev_ld, LEFT_DUTY}, 32'h0);
      end
      prev_rd = RIGHT_DUTY; prev_ld = LEFT_DUTY;
      prev_rf = RIGHT_FWD;  prev_lf = LEFT_FWD;
      have_prev = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] rd;
  int          cyc;
  int          rev_duty [10];
  int          rev_fwd  [10];
  int          ab_duty  [7];
  int          op;
  int          k;

  initial begin
    vecs[0] = '{2'd1, 32'h0000_0000, 32'h0000_0001};
    vecs[1] = '{2'd1, 32'h0000_01FF, 32'h0000_007F};
    vecs[2] = '{2'd1, 32'hFFFF_FF8A, 32'h0000_000A};
    vecs[3] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_C993};
    vecs[4] = '{2'd0, 32'hABCD_0003, 32'h0000_0003};
    vecs[5] = '{2'd3, 32'h1234_5678, 32'h0000_0000};
    vecs[6] = '{2'd0, 32'h0000_8CA6, 32'h0000_8CA6};
    rev_duty = '{30, 20, 10, 0, 0, 0, 0, 10, 20, 20};
    rev_fwd  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    ab_duty  = '{20, 10, 0, 0, 0, 10, 20};

    // Reset state
    PRESERN = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk_en = 1'b1;
    checkOutput("rst_outputs", pack_out(), 32'h0000_C000);
    checkOutput("rst_ready_slverr", {30'h0, PREADY, PSLVERR}, 32'h2);
    apbRead(32'h8, rd);  checkOutput("rst_status", rd, 32'h0000_C000);
    apbRead(32'h4, rd);  checkOutput("rst_step", rd, 32'h1);
    apbRead(32'h0, rd);  checkOutput("rst_target", rd, 32'h3);
    PRESERN = 1'b1;
    @(posedge PCLK); #1;

    // Register write/read-back vectors
    for (int i = 0; i < 7; i++) begin
      applyStimulus({28'h0, vecs[i].addr, 2'b00}, vecs[i].wdata);
      apbRead({28'h0, vecs[i].addr, 2'b00}, rd);
      checkOutput($sformatf("vec%0d", i), rd, vecs[i].rexp);
    end

    PRESERN = 1'b0;
    @(posedge PCLK); #1;
    PRESERN = 1'b1;

    // Ramp up, right forward to 25 at step 10
    applyStimulus(32'h4, 32'd10);
    applyStimulus(32'h0, 32'h65);
    waitTick(cyc);
    checkOutput("ramp_t1", {25'h0, RIGHT_DUTY}, 32'd10);
    apbRead(32'h8, rd); checkOutput("ramp_busy_set", {31'h0, rd[16]}, 32'h1);
    waitTick(cyc);
    checkOutput("ramp_t2", {25'h0, RIGHT_DUTY}, 32'd20);
    checkOutput("tick_period_a", 32'(cyc), 32'(TICK_DIV));
    waitTick(cyc);
    checkOutput("ramp_t3", {25'h0, RIGHT_DUTY}, 32'd25);
    checkOutput("tick_period_b", 32'(cyc), 32'(TICK_DIV));
    waitTick(cyc);
    checkOutput("ramp_hold", {25'h0, RIGHT_DUTY}, 32'd25);
    apbRead(32'h8, rd); checkOutput("ramp_busy_clear", {31'h0, rd[16]}, 32'h0);

    // Clamp of an out-of-range duty
    applyStimulus(32'h0, 32'h1FD);
    apbRead(32'h0, rd); checkOutput("clamp_target", rd, 32'h191);
    for (int i = 0; i < 10; i++) begin
      waitTick(cyc);
      checkOutput("clamp_le100", {31'h0, (RIGHT_DUTY <= 7'd100)}, 32'h1);
    end
    checkOutput("clamp_final", {25'h0, RIGHT_DUTY}, 32'd100);

    // Full reversal from 30 forward to 20 reverse
    applyStimulus(32'h0, 32'h79);
    for (int i = 0; i < 8; i++) waitTick(cyc);
    checkOutput("rev_start", {24'h0, RIGHT_FWD, RIGHT_DUTY}, 32'h9E);
    applyStimulus(32'h0, 32'h50);
    for (int i = 0; i < 10; i++) begin
      waitTick(cyc);
      checkOutput($sformatf("rev_t%0d", i + 1), {24'h0, RIGHT_FWD, RIGHT_DUTY},
                  32'(128 * rev_fwd[i] + rev_duty[i]));
    end

    // Abort a reversal while in the dead time
    applyStimulus(32'h0, 32'h51);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        apbRead(32'h8, rd); checkOutput("abort_busy_dead", {31'h0, rd[16]}, 32'h1);
        applyStimulus(32'h0, 32'h50);
      end
      waitTick(cyc);
      checkOutput($sformatf("abort_t%0d", i + 1), {24'h0, RIGHT_FWD, RIGHT_DUTY}, 32'(ab_duty[i]));
    end
    apbRead(32'h8, rd); checkOutput("abort_busy_clear", {31'h0, rd[16]}, 32'h0);

    // Reset in the middle of a left ramp
    applyStimulus(32'h0, 32'hC852);
    k = 0;
    while (m_duty[1] != 40 && k < 20) begin
      waitTick(cyc);
      k++;
    end
    checkOutput("midreset_pre", {24'h0, LEFT_FWD, LEFT_DUTY}, 32'hA8);
    PRESERN = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("midreset_outputs", pack_out(), 32'h0000_C000);
    apbRead(32'h0, rd); checkOutput("midreset_target", rd, 32'h3);
    PRESERN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      waitTick(cyc);
      checkOutput("midreset_idle", pack_out(), 32'h0000_C000);
    end

    // Random APB traffic against the model
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 40) begin
        applyStimulus({$urandom} & 32'hFFFF_FFF3, $urandom);
      end else if (op < 55) begin
        applyStimulus(({$urandom} & 32'hFFFF_FFF3) | 32'h4,
                      ($urandom_range(0, 3) == 0) ? ({$urandom} & 32'hFFFF_FF80) : $urandom);
      end else if (op < 60) begin
        applyStimulus(({$urandom} & 32'hFFFF_FFF3) | 32'h8 | ({$urandom} & 32'h4), $urandom);
      end else if (op < 97) begin
        k = int'($urandom_range(0, 3));
        apbRead(({$urandom} & 32'hFFFF_FFF3) | 32'(4 * k), rd);
        checkOutput($sformatf("rand_read_a%0d", k), rd, model_read(k));
      end else begin
        PRESERN = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge PCLK); #1; end
        PRESERN = 1'b1;
      end
      repeat ($urandom_range(0, 12)) begin @(posedge PCLK); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
